// File: rtl/round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : round_ctrl
// Purpose  : Round controller. Tracks lives and score, freezes and blinks the
//            frog on a hit, respawns it, and holds in game-over until restart.
// Revision : 1.0  initial release
// ============================================================================
module round_ctrl #(
    parameter int LIVES         = 3,
    parameter int FREEZE_CYCLES = 8,
    parameter int BLINK_HALF    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       win,
    input  logic       start,
    output logic       frogClear,
    output logic       obsHold,
    output logic       frogBlank,
    output logic [1:0] livesLeft,
    output logic [3:0] score,
    output logic       gameOver
);

    localparam int c_frz_w = $clog2(FREEZE_CYCLES);
    localparam int c_blk_w = $clog2(BLINK_HALF + 1);

    localparam logic [c_frz_w-1:0] c_frz_load = c_frz_w'(FREEZE_CYCLES - 1);
    localparam logic [c_blk_w-1:0] c_blk_load = c_blk_w'(BLINK_HALF - 1);
    localparam logic [1:0]         c_lives    = 2'(LIVES);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        HIT     = 2'd1,
        RESPAWN = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           lives_q, lives_d;
    logic [3:0]           score_q, score_d;
    logic [c_frz_w-1:0]   frz_q, frz_d;
    logic [c_blk_w-1:0]   blink_q, blink_d;
    logic                 blank_q, blank_d;
    logic                 clear_q, clear_d;
    logic                 hold_q, hold_d;
    logic                 over_q, over_d;
    logic                 win_prev_q, win_prev_d;

    logic                 w_win_rise;

    assign w_win_rise = win & ~win_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            lives_q    <= c_lives;
            score_q    <= 4'd0;
            frz_q      <= '0;
            blink_q    <= '0;
            blank_q    <= 1'b0;
            clear_q    <= 1'b0;
            hold_q     <= 1'b0;
            over_q     <= 1'b0;
            win_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            frz_q      <= frz_d;
            blink_q    <= blink_d;
            blank_q    <= blank_d;
            clear_q    <= clear_d;
            hold_q     <= hold_d;
            over_q     <= over_d;
            win_prev_q <= win_prev_d;
        end
    end

    // Registered outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        score_d    = score_q;
        frz_d      = frz_q;
        blink_d    = blink_q;
        blank_d    = blank_q;
        clear_d    = 1'b0;
        hold_d     = hold_q;
        over_d     = over_q;
        win_prev_d = win;

        case (state_q)
            PLAY: begin
                hold_d  = 1'b0;
                blank_d = 1'b0;
                over_d  = 1'b0;
                if (hit) begin
                    hold_d = 1'b1;
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = HIT;
                        frz_d   = c_frz_load;
                        blink_d = c_blk_load;
                        blank_d = 1'b1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = OVER;
                        over_d  = 1'b1;
                    end
                end else if (w_win_rise) begin
                    if (score_q != 4'd15) begin
                        score_d = score_q + 4'd1;
                    end
                    clear_d = 1'b1;
                end
            end

            HIT: begin
                hold_d = 1'b1;
                if (blink_q == '0) begin
                    blank_d = ~blank_q;
                    blink_d = c_blk_load;
                end else begin
                    blink_d = blink_q - c_blk_w'(1);
                end
                if (frz_q == '0) begin
                    state_d = RESPAWN;
                    clear_d = 1'b1;
                    blank_d = 1'b0;
                    blink_d = '0;
                end else begin
                    frz_d = frz_q - c_frz_w'(1);
                end
            end

            RESPAWN: begin
                state_d = PLAY;
                hold_d  = 1'b0;
                blank_d = 1'b0;
                over_d  = 1'b0;
            end

            default: begin // OVER
                over_d  = 1'b1;
                hold_d  = 1'b1;
                blank_d = 1'b0;
                lives_d = 2'd0;
                if (start) begin
                    lives_d = c_lives;
                    score_d = 4'd0;
                    state_d = RESPAWN;
                    clear_d = 1'b1;
                    over_d  = 1'b0;
                end
            end
        endcase
    end

    assign frogClear = clear_q;
    assign obsHold   = hold_q;
    assign frogBlank = blank_q;
    assign livesLeft = lives_q;
    assign score     = score_q;
    assign gameOver  = over_q;

endmodule
`default_nettype wire

// File: tb/tb_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_ctrl
// Purpose  : Directed self-checking bench for round_ctrl (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_round_ctrl;

    logic       clk;
    logic       reset;
    logic       hit;
    logic       win;
    logic       start;
    logic       frogClear;
    logic       obsHold;
    logic       frogBlank;
    logic [1:0] livesLeft;
    logic [3:0] score;
    logic       gameOver;

    int total;
    int bad;

    round_ctrl #(
        .LIVES        (3),
        .FREEZE_CYCLES(8),
        .BLINK_HALF   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hit      (hit),
        .win      (win),
        .start    (start),
        .frogClear(frogClear),
        .obsHold  (obsHold),
        .frogBlank(frogBlank),
        .livesLeft(livesLeft),
        .score    (score),
        .gameOver (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One-cycle hit pulse from PLAY, then ride through HIT and RESPAWN back to PLAY.
    task automatic hit_and_recover();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        repeat (9) tick();
    endtask

    logic [7:0] blink_pat;
    logic [3:0] exp_score;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        hit   = 1'b0;
        win   = 1'b0;
        start = 1'b0;
        blink_pat = 8'b0011_0011;

        #2;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_lives", livesLeft, 3);
        check("rst_score", score, 0);
        check("rst_clear", frogClear, 0);
        check("rst_hold", obsHold, 0);
        check("rst_blank", frogBlank, 0);
        check("rst_over", gameOver, 0);

        // Single hit: blink pattern, respawn, return to play.
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_lives", livesLeft, 2);
        for (int i = 0; i < 8; i++) begin
            check("hit_blank", frogBlank, blink_pat[i]);
            check("hit_hold", obsHold, 1);
            check("hit_clear", frogClear, 0);
            tick();
        end
        check("resp_clear", frogClear, 1);
        check("resp_hold", obsHold, 1);
        check("resp_blank", frogBlank, 0);
        tick();
        check("play_hold", obsHold, 0);
        check("play_clear", frogClear, 0);

        // Simultaneous hit and win: hit wins; pulses during HIT are ignored.
        do_reset();
        hit = 1'b1;
        win = 1'b1;
        tick();
        hit = 1'b0;
        win = 1'b0;
        check("hw_lives", livesLeft, 2);
        check("hw_score", score, 0);
        check("hw_clear", frogClear, 0);
        check("hw_hold", obsHold, 1);
        tick();
        hit = 1'b1;
        win = 1'b1;
        tick();
        hit = 1'b0;
        win = 1'b0;
        tick();
        check("hit_ign_lives", livesLeft, 2);
        check("hit_ign_score", score, 0);
        repeat (6) tick();
        check("hw_back_hold", obsHold, 0);
        check("hw_back_lives", livesLeft, 2);

        // Reset during the 4th HIT cycle.
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        tick();
        tick();
        check("hit4_hold", obsHold, 1);
        do_reset();
        check("rsthit_lives", livesLeft, 3);
        check("rsthit_hold", obsHold, 0);
        check("rsthit_blank", frogBlank, 0);
        check("rsthit_over", gameOver, 0);

        // Start outside OVER does nothing.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_play_clear", frogClear, 0);
        check("start_play_lives", livesLeft, 3);

        // Three hits to game over, reset out of OVER.
        hit_and_recover();
        check("h1_lives", livesLeft, 2);
        hit_and_recover();
        check("h2_lives", livesLeft, 1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("h3_over", gameOver, 1);
        check("h3_lives", livesLeft, 0);
        check("h3_clear", frogClear, 0);
        check("h3_hold", obsHold, 1);
        tick();
        tick();
        check("over_stay", gameOver, 1);
        check("over_clear", frogClear, 0);
        do_reset();
        check("rstover_over", gameOver, 0);
        check("rstover_lives", livesLeft, 3);
        check("rstover_hold", obsHold, 0);
        check("rstover_blank", frogBlank, 0);

        // Game over again, then restart via start. Hit/win ignored in OVER.
        win = 1'b1;
        tick();
        win = 1'b0;
        check("pre_score", score, 1);
        hit_and_recover();
        hit_and_recover();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("g2_over", gameOver, 1);
        hit = 1'b1;
        win = 1'b1;
        tick();
        hit = 1'b0;
        win = 1'b0;
        tick();
        check("over_score_frozen", score, 1);
        check("over_lives_zero", livesLeft, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_clear", frogClear, 1);
        check("st_lives", livesLeft, 3);
        check("st_score", score, 0);
        check("st_over", gameOver, 0);
        tick();
        check("st_play_clear", frogClear, 0);
        check("st_play_hold", obsHold, 0);

        // Win held 4 cycles, 17 times: one count and one clear pulse per assertion.
        exp_score = 4'd0;
        for (int k = 0; k < 17; k++) begin
            win = 1'b1;
            tick();
            if (exp_score != 4'd15) exp_score = exp_score + 4'd1;
            check("win_clear", frogClear, 1);
            check("win_score", score, exp_score);
            for (int j = 0; j < 3; j++) begin
                tick();
                check("win_held_clear", frogClear, 0);
            end
            check("win_held_score", score, exp_score);
            win = 1'b0;
            tick();
        end
        check("win_sat", score, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
